// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, EX redirects, data-memory wait stalls,
// memory-timeout watchdog and stall/flush performance counters. Outputs are Mealy, zero in reset.
module hazard_ctrl #(
   parameter int LOAD_LAT    = 1,
   parameter int MEM_TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  ID_rs1_add_i,
   input  logic [4:0]  ID_rs2_add_i,
   input  logic        ID_use_rs1_i,
   input  logic        ID_use_rs2_i,
   input  logic [4:0]  EX_rd_add_i,
   input  logic        EX_mem_rd_en_i,
   input  logic        EX_redirect_i,
   input  logic        MEM_req_i,
   input  logic        MEM_ready_i,
   output logic        pc_stall_o,
   output logic        ifid_stall_o,
   output logic        ifid_flush_o,
   output logic        idex_stall_o,
   output logic        idex_flush_o,
   output logic        exmem_stall_o,
   output logic        err_o,
   output logic [31:0] stall_cnt_o,
   output logic [31:0] flush_cnt_o
);

   typedef enum logic {RUN, LU_STALL} state_t;

   localparam logic [3:0]  LU_INIT = 4'(LOAD_LAT - 1);
   localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);

   state_t      state_q, state_d;
   logic [3:0]  lu_cnt_q, lu_cnt_d;
   logic [15:0] wait_cnt_q, wait_cnt_d;
   logic        err_q, err_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   logic mstall, lu;
   logic pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall;

   assign mstall = MEM_req_i & ~MEM_ready_i;
   assign lu     = EX_mem_rd_en_i & (EX_rd_add_i != 5'd0) &
                   ((ID_use_rs1_i & (ID_rs1_add_i == EX_rd_add_i)) |
                    (ID_use_rs2_i & (ID_rs2_add_i == EX_rd_add_i)));

   always_comb begin
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      ifid_flush  = 1'b0;
      idex_stall  = 1'b0;
      idex_flush  = 1'b0;
      exmem_stall = 1'b0;
      state_d     = state_q;
      lu_cnt_d    = lu_cnt_q;
      flush_cnt_d = flush_cnt_q;

      if (mstall) begin
         // Whole pipe freezes; EX inputs hold so pending events re-evaluate afterwards.
         pc_stall    = 1'b1;
         ifid_stall  = 1'b1;
         idex_stall  = 1'b1;
         exmem_stall = 1'b1;
      end else if (EX_redirect_i) begin
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         flush_cnt_d = flush_cnt_q + 32'd1;
         state_d     = RUN;
         lu_cnt_d    = 4'd0;
      end else if (state_q == LU_STALL) begin
         pc_stall   = 1'b1;
         ifid_stall = 1'b1;
         idex_flush = 1'b1;
         lu_cnt_d   = lu_cnt_q - 4'd1;
         if (lu_cnt_q == 4'd1) state_d = RUN;
      end else if (lu) begin
         pc_stall   = 1'b1;
         ifid_stall = 1'b1;
         idex_flush = 1'b1;
         if (LOAD_LAT > 1) begin
            state_d  = LU_STALL;
            lu_cnt_d = LU_INIT;
         end
      end
   end

   always_comb begin
      wait_cnt_d = 16'd0;
      if (mstall) wait_cnt_d = (wait_cnt_q == 16'hFFFF) ? wait_cnt_q : wait_cnt_q + 16'd1;
      err_d       = err_q | (mstall & (wait_cnt_d == TIMEOUT));
      stall_cnt_d = stall_cnt_q + {31'd0, pc_stall};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         lu_cnt_q    <= 4'd0;
         wait_cnt_q  <= 16'd0;
         err_q       <= 1'b0;
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         lu_cnt_q    <= lu_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         err_q       <= err_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Gate with rst_n so the Mealy controls are quiet while reset is held.
   assign pc_stall_o    = rst_n & pc_stall;
   assign ifid_stall_o  = rst_n & ifid_stall;
   assign ifid_flush_o  = rst_n & ifid_flush;
   assign idex_stall_o  = rst_n & idex_stall;
   assign idex_flush_o  = rst_n & idex_flush;
   assign exmem_stall_o = rst_n & exmem_stall;
   assign err_o         = err_q;
   assign stall_cnt_o   = stall_cnt_q;
   assign flush_cnt_o   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench: two hazard_ctrl instances (LOAD_LAT 1 and 3, MEM_TIMEOUT 8) share stimulus;
// a cycle-level reference model predicts each instance's outputs and a monitor compares them.
module tb_hazard_ctrl;

   typedef struct packed {
      logic [5:0]  ctl;   // {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall}
      logic        err;
      logic [31:0] sc;
      logic [31:0] fc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
   logic       use1 = 1'b0, use2 = 1'b0, ld = 1'b0, redir = 1'b0, req = 1'b0, rdy = 1'b0;

   logic [5:0]  ctl_a [2];
   logic        err_a [2];
   logic [31:0] sc_a  [2];
   logic [31:0] fc_a  [2];

   exp_t q0[$];
   exp_t q1[$];

   int vectors = 0;
   int miscompares = 0;

   // reference model state: remaining bubbles after the current one, wait run length, counters
   int          lat  [2] = '{1, 3};
   int          bub  [2];
   int          wcnt [2];
   bit          errm [2];
   logic [31:0] scm  [2];
   logic [31:0] fcm  [2];

   always #5 clk = ~clk;

   genvar g;
   for (g = 0; g < 2; g++) begin : g_dut
      hazard_ctrl #(.LOAD_LAT(g == 0 ? 1 : 3), .MEM_TIMEOUT(8)) u_dut (
         .clk           (clk),
         .rst_n         (rst_n),
         .ID_rs1_add_i  (rs1),
         .ID_rs2_add_i  (rs2),
         .ID_use_rs1_i  (use1),
         .ID_use_rs2_i  (use2),
         .EX_rd_add_i   (rd),
         .EX_mem_rd_en_i(ld),
         .EX_redirect_i (redir),
         .MEM_req_i     (req),
         .MEM_ready_i   (rdy),
         .pc_stall_o    (ctl_a[g][5]),
         .ifid_stall_o  (ctl_a[g][4]),
         .ifid_flush_o  (ctl_a[g][3]),
         .idex_stall_o  (ctl_a[g][2]),
         .idex_flush_o  (ctl_a[g][1]),
         .exmem_stall_o (ctl_a[g][0]),
         .err_o         (err_a[g]),
         .stall_cnt_o   (sc_a[g]),
         .flush_cnt_o   (fc_a[g])
      );
   end

   task automatic apply(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                        input logic u1, input logic u2, input logic [4:0] d,
                        input logic l, input logic rx, input logic mq, input logic my);
      exp_t e;
      bit   mst, hz;
      @(posedge clk);
      #1;
      rst_n = r; rs1 = a1; rs2 = a2; use1 = u1; use2 = u2;
      rd = d; ld = l; redir = rx; req = mq; rdy = my;
      mst = mq && !my;
      hz  = l && (d != 0) && ((u1 && a1 == d) || (u2 && a2 == d));
      for (int k = 0; k < 2; k++) begin
         if (!r) begin
            e = '0;
            bub[k] = 0; wcnt[k] = 0; errm[k] = 0; scm[k] = 0; fcm[k] = 0;
         end else begin
            e.ctl = 6'b000000;
            e.err = errm[k];
            e.sc  = scm[k];
            e.fc  = fcm[k];
            if (mst) begin
               e.ctl   = 6'b110101;
               scm[k]  = scm[k] + 1;
               wcnt[k] = (wcnt[k] < 65535) ? wcnt[k] + 1 : 65535;
               if (wcnt[k] == 8) errm[k] = 1;
            end else begin
               wcnt[k] = 0;
               if (rx) begin
                  e.ctl  = 6'b001010;
                  fcm[k] = fcm[k] + 1;
                  bub[k] = 0;
               end else if (bub[k] > 0 || hz) begin
                  e.ctl  = 6'b110010;
                  scm[k] = scm[k] + 1;
                  bub[k] = (bub[k] > 0) ? bub[k] - 1 : lat[k] - 1;
               end
            end
         end
         if (k == 0) q0.push_back(e);
         else        q1.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic mwait(input int n);
      for (int i = 0; i < n; i++) apply(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
   endtask

   task automatic check(input int k, input exp_t e);
      vectors++;
      if (ctl_a[k] !== e.ctl || err_a[k] !== e.err || sc_a[k] !== e.sc || fc_a[k] !== e.fc) begin
         miscompares++;
         $display("FAIL dut%0d t=%0t: got ctl=%b err=%b stall_cnt=%0d flush_cnt=%0d, expected ctl=%b err=%b stall_cnt=%0d flush_cnt=%0d",
                  k, $time, ctl_a[k], err_a[k], sc_a[k], fc_a[k], e.ctl, e.err, e.sc, e.fc);
      end
   endtask

   always @(negedge clk) begin
      if (q0.size() > 0) check(0, q0.pop_front());
      if (q1.size() > 0) check(1, q1.pop_front());
   end

   initial begin
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(2);
      apply(1, 5, 0, 1, 0, 5, 1, 0, 0, 0);    // load-use on rs1
      idle(4);
      apply(1, 0, 0, 1, 1, 0, 1, 0, 0, 0);    // rd = x0: no hazard
      idle(2);
      apply(1, 3, 7, 0, 1, 7, 1, 1, 0, 0);    // redirect beats load-use on rs2
      idle(2);
      mwait(4);
      apply(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      idle(2);
      apply(1, 9, 0, 1, 0, 9, 1, 0, 0, 0);    // memory wait lands inside the bubble
      idle(1);
      mwait(2);
      idle(3);
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(1);
      mwait(7);                                // one short of the timeout
      idle(2);
      mwait(10);
      idle(3);
      apply(1, 4, 0, 1, 0, 4, 1, 0, 0, 0);
      idle(1);
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);    // async reset mid-bubble
      idle(2);
      for (int i = 0; i < 2000; i++) begin
         apply(($urandom_range(0, 299) != 0),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 1)));
      end
      repeat (3) @(negedge clk);
      #1;
      if (q0.size() != 0 || q1.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d/%0d entries left, expected 0", q0.size(), q1.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
